// File: rtl/conv_window_sched.sv
// conv_window_sched: streams one conv layer's input feature map, channel by channel,
// from frame RAM into the 3x3 window generator. After each channel's real pixels it
// pushes zero flush pixels, then waits until every window of the channel is accepted.
module conv_window_sched #(
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_CH = 16,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(MAX_CH+1)-1:0] num_ch,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [DATA_W-1:0]           pix_out,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        pix_flush,
  input  logic                        win_valid,
  input  logic                        win_ready,
  output logic [$clog2(MAX_CH)-1:0]   ch_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned NumPix   = IMG_H * IMG_W;
  localparam int unsigned NumFlush = IMG_W + 1;
  localparam int unsigned PixW     = $clog2(NumPix + 1);
  localparam int unsigned FlushW   = $clog2(NumFlush + 1);
  localparam int unsigned NchW     = $clog2(MAX_CH + 1);
  localparam int unsigned ChW      = $clog2(MAX_CH);

  typedef enum logic [2:0] {StIdle, StRead, StFlush, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [NchW-1:0]   num_ch_q, num_ch_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [PixW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic [PixW-1:0]   win_cnt_q, win_cnt_d;
  logic [PixW-1:0]   win_cnt_inc;

  // Skid storage: a read issued last cycle is "in flight" and its data sits on mem_rdata now.
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;

  logic              fifo_empty;
  logic              real_valid;
  logic [DATA_W-1:0] real_data;
  logic              flush_valid;
  logic              flush_xfer;
  logic              rd_room;
  logic              push;
  logic              pop;
  logic              win_acc;

  // Output path: stored pixels first, else the in-flight RAM word passes straight through,
  // else (only once nothing real is pending) a zero flush pixel.
  always_comb begin
    fifo_empty  = (occ_q == 2'd0);
    real_valid  = !fifo_empty || inflight_q;
    real_data   = fifo_empty ? mem_rdata : fifo_q[rd_ptr_q];
    flush_valid = (state_q == StFlush) && !real_valid;
    flush_xfer  = flush_valid && pix_ready;
    // Stored + in-flight must stay below 2 so the 2-entry buffer can never overflow.
    rd_room     = fifo_empty || ((occ_q == 2'd1) && !inflight_q);
    pop         = !fifo_empty && pix_ready;
    push        = inflight_q && !(fifo_empty && pix_ready);
    win_acc     = win_valid && win_ready && (state_q != StIdle) &&
                  (win_cnt_q < PixW'(NumPix));
    win_cnt_inc = win_cnt_q + PixW'(win_acc);
  end

  assign mem_rd_en = (state_q == StRead) && (num_ch_q != '0) && rd_room;
  assign mem_addr  = addr_q;
  assign pix_valid = real_valid || flush_valid;
  assign pix_out   = real_valid ? real_data : '0;
  assign pix_flush = flush_valid;
  assign ch_idx    = ch_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  // Skid buffer and read-latency tracking; reset discards any word still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      inflight_q <= mem_rd_en;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Sequencer state and per-layer/per-channel counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      num_ch_q    <= '0;
      ch_q        <= '0;
      rd_cnt_q    <= '0;
      addr_q      <= '0;
      flush_cnt_q <= '0;
      win_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_ch_q    <= num_ch_d;
      ch_q        <= ch_d;
      rd_cnt_q    <= rd_cnt_d;
      addr_q      <= addr_d;
      flush_cnt_q <= flush_cnt_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  // Next-state logic: raster reads, flush, wait for windows, then next channel or finish.
  always_comb begin
    state_d     = state_q;
    num_ch_d    = num_ch_q;
    ch_d        = ch_q;
    rd_cnt_d    = rd_cnt_q;
    addr_d      = addr_q;
    flush_cnt_d = flush_cnt_q;
    win_cnt_d   = win_cnt_inc;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_ch_d    = num_ch;
          ch_d        = '0;
          rd_cnt_d    = '0;
          addr_d      = '0;
          flush_cnt_d = '0;
          win_cnt_d   = '0;
          state_d     = StRead;
        end
      end
      StRead: begin
        if (num_ch_q == '0) begin
          state_d = StDone;
        end else if (mem_rd_en) begin
          // Channels are contiguous in RAM, so one running address covers the whole layer.
          rd_cnt_d = rd_cnt_q + PixW'(1);
          addr_d   = addr_q + ADDR_W'(1);
          if (rd_cnt_q == PixW'(NumPix - 1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_xfer) begin
          flush_cnt_d = flush_cnt_q + FlushW'(1);
          if (flush_cnt_q == FlushW'(NumFlush - 1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Looks at the post-accept count so the final window and the exit share a cycle.
        if (win_cnt_inc == PixW'(NumPix)) begin
          if ((NchW'(ch_q) + NchW'(1)) == num_ch_q) begin
            state_d = StDone;
          end else begin
            ch_d        = ch_q + ChW'(1);
            rd_cnt_d    = '0;
            flush_cnt_d = '0;
            win_cnt_d   = '0;
            state_d     = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched: RAM model, 3x3 window generator model and a
// transaction-level reference of addresses, pixel stream, windows, busy and done.
module tb_conv_window_sched;

  localparam int NPIX = 28 * 28;
  localparam int NFL  = 28 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] num_ch = '0;
  logic       mem_rd_en;
  logic [13:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       pix_flush;
  logic       win_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic [3:0] ch_idx;
  logic       busy;
  logic       done;

  conv_window_sched #(
    .IMG_H (28),
    .IMG_W (28),
    .DATA_W(8),
    .MAX_CH(16),
    .ADDR_W(14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_ch   (num_ch),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .pix_out  (pix_out),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_flush(pix_flush),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .ch_idx   (ch_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input int a);
    int v;
    v = a * 37 + 11 + (a >> 8);
    return v[7:0];
  endfunction

  // Synchronous-read frame RAM: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram_val(int'(mem_addr));
  end

  int checks = 0, failures = 0, cyc = 0;

  // Stimulus controls
  bit         drv_start = 0, drv_rst = 0, win_hold = 0;
  logic [4:0] drv_num_ch = '0;
  int         pix_pct = 100, win_pct = 100;

  // Reference model state
  bit exp_busy;
  int done_cd, layer_nch, exp_addr, reads, real_xfer;
  int pix_ch, pix_i, gen_cnt, win_pend, win_ch, win_acc;
  bit prev_stall, prev_flush;
  logic [7:0] prev_out;

  // Observations for literal checks
  int n_done, done_cycle, start_cycle, first_rd_cycle, last_rd_cycle, first_pix_cycle;
  int first_addr, last_addr, addr_ch1, ch_changes, last_ch, flush_seen, last_win_cycle;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_busy = 0; done_cd = 0; layer_nch = 0; exp_addr = 0; reads = 0; real_xfer = 0;
    pix_ch = 0; pix_i = 0; gen_cnt = 0; win_pend = 0; win_ch = 0; win_acc = 0;
    prev_stall = 0; prev_flush = 0; prev_out = '0;
  endtask

  task automatic clear_stats();
    n_done = 0; done_cycle = -1; start_cycle = -1; first_rd_cycle = -1; last_rd_cycle = -1;
    first_pix_cycle = -1; first_addr = -1; last_addr = -1; addr_ch1 = -1; ch_changes = 0;
    last_ch = 0; flush_seen = 0; last_win_cycle = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(done == 1'b0, {tag, "_done"}, done, 0);
    chk(mem_rd_en == 1'b0, {tag, "_rd_en"}, mem_rd_en, 0);
    chk(mem_addr == '0, {tag, "_addr"}, mem_addr, 0);
    chk(pix_valid == 1'b0, {tag, "_pix_valid"}, pix_valid, 0);
    chk(pix_flush == 1'b0, {tag, "_pix_flush"}, pix_flush, 0);
    chk(pix_out == '0, {tag, "_pix_out"}, pix_out, 0);
    chk(ch_idx == '0, {tag, "_ch_idx"}, ch_idx, 0);
  endtask

  // Per-cycle comparison against the reference model, then model update for this edge.
  task automatic evaluate();
    bit exp_done, nxt_busy, exp_fl;
    logic [7:0] exp_px;
    if (rst) model_reset();
    exp_done = (done_cd == 1);
    if (done_cd > 0) done_cd--;
    chk(busy == exp_busy, "busy", busy, exp_busy);
    chk(done == exp_done, "done", done, exp_done);
    if (done) begin n_done++; done_cycle = cyc; end

    if (mem_rd_en) begin
      chk(reads < layer_nch * NPIX, "read_count", reads + 1, layer_nch * NPIX);
      chk(int'(mem_addr) == exp_addr, "mem_addr", mem_addr, exp_addr);
      chk(int'(ch_idx) == exp_addr / NPIX, "ch_idx_rd", ch_idx, exp_addr / NPIX);
      if (reads == 0) begin first_rd_cycle = cyc; first_addr = int'(mem_addr); end
      if (int'(ch_idx) != last_ch) begin ch_changes++; last_ch = int'(ch_idx); end
      if (ch_idx == 4'd1 && addr_ch1 < 0) addr_ch1 = int'(mem_addr);
      last_addr = int'(mem_addr);
      last_rd_cycle = cyc;
      exp_addr++;
      reads++;
    end
    chk(reads - real_xfer <= 2, "outstanding", reads - real_xfer, 2);

    if (prev_stall) begin
      chk(pix_valid == 1'b1, "hold_valid", pix_valid, 1);
      chk(pix_out == prev_out, "hold_data", pix_out, prev_out);
      chk(pix_flush == prev_flush, "hold_flush", pix_flush, prev_flush);
    end
    if (pix_flush) chk(pix_valid && pix_out == '0, "flush_zero", pix_out, 0);
    if (pix_valid && first_pix_cycle < 0) first_pix_cycle = cyc;

    if (win_valid && win_ready) begin
      win_pend--;
      win_acc++;
      if (win_acc == NPIX) begin
        last_win_cycle = cyc;
        if (win_ch == layer_nch - 1) done_cd = 1;
        else begin win_ch++; win_acc = 0; end
      end
    end

    if (pix_valid && pix_ready) begin
      chk(pix_ch < layer_nch, "pixel_in_layer", pix_ch, layer_nch);
      if (pix_ch < layer_nch) begin
        if (pix_i < NPIX) begin exp_px = ram_val(pix_ch * NPIX + pix_i); exp_fl = 0; end
        else begin exp_px = '0; exp_fl = 1; end
        chk(pix_out == exp_px, "pix_out", pix_out, exp_px);
        chk(pix_flush == exp_fl, "pix_flush", pix_flush, exp_fl);
        pix_i++;
        gen_cnt++;
        if (gen_cnt > NFL) win_pend++;
        if (pix_i == NPIX + NFL) begin pix_ch++; pix_i = 0; gen_cnt = 0; end
      end
      if (pix_flush) flush_seen++;
      else real_xfer++;
    end

    nxt_busy = exp_busy;
    if (exp_done) nxt_busy = 0;
    if (start && !exp_busy && !rst) begin
      nxt_busy = 1; layer_nch = int'(num_ch); exp_addr = 0; reads = 0; real_xfer = 0;
      pix_ch = 0; pix_i = 0; gen_cnt = 0; win_ch = 0; win_acc = 0; start_cycle = cyc;
      first_rd_cycle = -1; first_pix_cycle = -1; last_ch = 0;
      if (num_ch == '0) done_cd = 2;
    end
    exp_busy   = nxt_busy;
    prev_stall = pix_valid && !pix_ready;
    prev_out   = pix_out;
    prev_flush = pix_flush;
  endtask

  task automatic step();
    @(negedge clk);
    rst       = drv_rst;
    pix_ready = ($urandom_range(99) < pix_pct);
    win_ready = win_hold ? 1'b0 : ($urandom_range(99) < win_pct);
    win_valid = (win_pend > 0);
    start     = drv_start;
    num_ch    = drv_num_ch;
    drv_start = 0;
    #1;
    evaluate();
    cyc++;
  endtask

  task automatic kick(input int nch);
    drv_num_ch = 5'(nch);
    drv_start  = 1;
    step();
  endtask

  task automatic run_until_done(input int budget);
    int d0, k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin step(); k++; end
    chk(n_done != d0, "done_timeout", k, budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_stats();
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    drv_rst = 1;
    repeat (3) step();
    drv_rst = 0;
    repeat (2) step();

    // Single channel, full throughput
    clear_stats();
    pix_pct = 100; win_pct = 100;
    kick(1);
    run_until_done(3000);
    step();
    chk(busy == 1'b0, "t1_busy_after_done", busy, 0);
    chk(reads == 784, "t1_reads", reads, 784);
    chk(first_addr == 0, "t1_first_addr", first_addr, 0);
    chk(last_addr == 783, "t1_last_addr", last_addr, 783);
    chk(last_rd_cycle - first_rd_cycle == 783, "t1_back_to_back", last_rd_cycle - first_rd_cycle, 783);
    chk(first_rd_cycle - start_cycle == 1, "t1_rd_latency", first_rd_cycle - start_cycle, 1);
    chk(first_pix_cycle - start_cycle == 2, "t1_pix_latency", first_pix_cycle - start_cycle, 2);
    chk(flush_seen == 29, "t1_flush_count", flush_seen, 29);
    chk(n_done == 1, "t1_done_count", n_done, 1);
    repeat (3) step();

    // Three channels
    clear_stats();
    kick(3);
    run_until_done(8000);
    chk(addr_ch1 == 784, "t2_first_ch1_addr", addr_ch1, 784);
    chk(last_addr == 2351, "t2_last_addr", last_addr, 2351);
    chk(ch_changes == 2, "t2_ch_changes", ch_changes, 2);
    chk(last_ch == 2, "t2_last_ch", last_ch, 2);
    chk(flush_seen == 87, "t2_flush_count", flush_seen, 87);
    repeat (3) step();
    chk(n_done == 1, "t2_done_count", n_done, 1);

    // Random backpressure, with a start pulse while busy
    clear_stats();
    pix_pct = 50; win_pct = 70;
    kick(1);
    repeat (50) step();
    kick(5);
    run_until_done(6000);
    repeat (3) step();
    chk(real_xfer == 784, "t3_real_pixels", real_xfer, 784);
    chk(reads == 784, "t3_reads", reads, 784);
    chk(n_done == 1, "t3_done_count", n_done, 1);

    // Windows held off while draining
    begin
      int k;
      clear_stats();
      pix_pct = 100; win_pct = 100; win_hold = 1;
      kick(1);
      k = 0;
      while (flush_seen < 29 && k < 3000) begin step(); k++; end
      chk(flush_seen == 29, "t4_reach_drain", flush_seen, 29);
      repeat (100) step();
      chk(n_done == 0, "t4_no_done_held", n_done, 0);
      chk(busy == 1'b1, "t4_busy_held", busy, 1);
      win_hold = 0;
      run_until_done(3000);
      chk(done_cycle - last_win_cycle == 1, "t4_done_after_win", done_cycle - last_win_cycle, 1);
      repeat (3) step();
    end

    // Reset in the middle of channel 1, then a fresh layer
    begin
      int k;
      clear_stats();
      kick(2);
      k = 0;
      while (reads < NPIX + 100 && k < 5000) begin step(); k++; end
      chk(ch_idx == 4'd1, "t5_in_ch1", ch_idx, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      drv_rst = 1;
      #1 check_reset_outputs("mid");
      model_reset();
      clear_stats();
      repeat (3) step();
      drv_rst = 0;
      repeat (3) step();
      chk(n_done == 0, "t5_no_abort_done", n_done, 0);
      kick(1);
      run_until_done(3000);
      chk(first_addr == 0, "t5_restart_addr", first_addr, 0);
      chk(reads == 784, "t5_reads", reads, 784);
      repeat (3) step();
      chk(n_done == 1, "t5_done_count", n_done, 1);
    end

    // Zero channels
    clear_stats();
    kick(0);
    repeat (5) step();
    chk(n_done == 1, "t6_done_count", n_done, 1);
    chk(done_cycle - start_cycle == 2, "t6_done_latency", done_cycle - start_cycle, 2);
    chk(reads == 0, "t6_reads", reads, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequences one convolution layer's input feature map through the 3x3 window generator.
- Per input channel: generates raster-order frame-RAM read addresses, absorbs the 1-cycle RAM read latency, and streams pixels to the window generator with valid/ready.
- After each channel's real pixels, pushes zero flush pixels so the bottom-row windows drain.
- Counts accepted windows per channel, loops over channels, and reports busy/done to the layer sequencer.

Parameters:
- IMG_H, 28, feature-map height.
- IMG_W, 28, feature-map width.
- DATA_W, 8, pixel width.
- MAX_CH, 16, maximum input channels per layer.
- ADDR_W, 14, frame-RAM address width; must satisfy 2^ADDR_W >= MAX_CH*IMG_H*IMG_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a layer, ignored unless IDLE.
- num_ch  in  $clog2(MAX_CH+1)  channel count, sampled at start; legal range 1..MAX_CH.
- mem_rd_en  out  1  frame-RAM read strobe.
- mem_addr  out  ADDR_W  read address = ch*IMG_H*IMG_W + row*IMG_W + col.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- pix_out  out  DATA_W  pixel to window generator.
- pix_valid  out  1  pix_out valid.
- pix_ready  in  1  window generator accepts; transfer = pix_valid & pix_ready.
- pix_flush  out  1  high with pix_valid on zero flush pixels (pix_out = 0).
- win_valid  in  1  window generator has a window.
- win_ready  in  1  MAC array accepts window; window accepted = win_valid & win_ready.
- ch_idx  out  $clog2(MAX_CH)  channel currently streaming.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window of the last channel.

Behaviour:
- Reset: FSM = IDLE; all counters = 0; skid buffer empty. Outputs mem_rd_en = 0, mem_addr = 0, pix_valid = 0, pix_flush = 0, pix_out = 0, ch_idx = 0, busy = 0, done = 0.
- Reset mid-layer aborts immediately: in-flight read data is discarded and no done pulse is produced.
- FSM states:
  - IDLE -> READ on start. Latch num_ch; if num_ch == 0 go directly to DONE.
  - READ: issue IMG_H*IMG_W reads for channel ch_idx in raster order (col fastest). Go to FLUSH after the last read is issued.
  - FLUSH: push IMG_W+1 zero pixels with pix_flush = 1, through the same output path after all real pixels. Go to DRAIN when the last flush pixel transfers.
  - DRAIN: wait until win_cnt == IMG_H*IMG_W. Then if ch_idx == num_ch-1 go to DONE; else increment ch_idx, clear counters, return to READ.
  - DONE: assert done for 1 cycle -> IDLE.
- Read flow control (2-entry skid FIFO feeding pix_out/pix_valid):
  - Issue mem_rd_en only when (FIFO occupancy + reads in flight) < 2, so no data is ever dropped.
  - Back-to-back reads are allowed, giving 1 pixel/cycle throughput with pix_ready held high.
  - First pixel appears on pix_valid 2 cycles after start: the start cycle, then the read cycle, then data is captured.
- pix_out/pix_valid stay stable while pix_valid & !pix_ready; pixels are never reordered, dropped or duplicated.
- win_cnt increments on each window accepted, in any non-IDLE state. Windows beyond IMG_H*IMG_W in a channel are ignored and not counted.
- mem_addr is computed by an incrementing counter, not a multiplier. It wraps nowhere within a layer.
- start while busy: ignored, no effect on state.
- Simultaneous final window accept and DRAIN check: the transition happens in the same cycle the count reaches IMG_H*IMG_W.

Test Plan:
- Single channel, pix_ready = win_ready = 1, model generator emits 1 window per pixel after IMG_W+1 pixels.
  - Required: 784 reads at addresses 0..783 back-to-back, then 29 flush zeros, done exactly once, busy low the cycle after done.
- num_ch = 3.
  - Required: ch_idx steps 0->1->2; first channel-1 address is 784, last address overall is 2351; done once at the end.
- Random pix_ready backpressure (50%).
  - Required: pix_out sequence equals RAM contents 0..783 in order with no loss or duplication; at most 2 reads outstanding in any cycle.
- Hold win_ready = 0 for 100 cycles during DRAIN.
  - Required: FSM stays in DRAIN, no done; done follows the 784th accepted window.
- Assert rst mid-READ of channel 1, then pulse start with num_ch = 1.
  - Required: all outputs return to reset values in the same cycle, no done from the aborted layer; the new layer starts at address 0.
- Pulse start while busy, and separately start with num_ch = 0.
  - Required: the first has no effect; the second gives no reads and done 2 cycles after start.
